// File: rtl/tangram_piece_arbiter_if.sv
// Bus between the user-input front end and tangram_piece_arbiter.
// The master drives switch/button levels; the slave returns grant, step pulses and scramble pulses.
interface tangram_piece_arbiter_if #(
    parameter int N_PIECES = 7
);
    logic [N_PIECES-1:0] select_sw;
    logic [3:0]          move_btn;
    logic                rotate;
    logic                scramble_req;
    logic                frame_tick;
    logic [N_PIECES-1:0] piece_sel;
    logic [3:0]          move_step;
    logic                rotate_pulse;
    logic [N_PIECES-1:0] disturb_flag;
    logic                busy;

    modport master (
        output select_sw, move_btn, rotate, scramble_req, frame_tick,
        input  piece_sel, move_step, rotate_pulse, disturb_flag, busy
    );

    modport slave (
        input  select_sw, move_btn, rotate, scramble_req, frame_tick,
        output piece_sel, move_step, rotate_pulse, disturb_flag, busy
    );
endinterface

// File: rtl/tangram_piece_arbiter.sv
// tangram_piece_arbiter: grants one tangram piece at a time, turns move/rotate
// presses into single-cycle steps for that piece, and sequences the scramble
// command as one disturb pulse per piece spaced GAP cycles apart.
// Optional feature: define TANGRAM_AUTOREPEAT_EN to add frame-based move auto-repeat.
module tangram_piece_arbiter #(
    parameter int N_PIECES           = 7,
    parameter int GAP                = 10,
    parameter int FIRST_DELAY_FRAMES = 20,
    parameter int REPEAT_FRAMES      = 8
) (
    input logic clk,
    input logic reset,
    tangram_piece_arbiter_if.slave bus
);
    localparam int IDX_W = (N_PIECES > 1) ? $clog2(N_PIECES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

    state_t              r_state, w_state_nxt;
    logic [7:0]          r_cnt;
    logic [IDX_W-1:0]    r_idx;

    logic [3:0]          r_move, r_move_d;
    logic                r_rot, r_rot_d;
    logic                r_scr, r_scr_d;

    logic [N_PIECES-1:0] r_piece_sel;
    logic [3:0]          r_move_step;
    logic                r_rotate_pulse;

    logic [N_PIECES-1:0] w_cand;
    logic [N_PIECES-1:0] w_disturb;
    logic [3:0]          w_rise, w_first, w_rep_step, w_step;
    logic                w_freeze, w_active, w_busy;
    logic                w_scr_rise, w_cnt_done, w_last;

    // Lowest-index set bit of the switches; all-zero when no switch is up.
    assign w_cand = bus.select_sw & (~bus.select_sw + {{(N_PIECES-1){1'b0}}, 1'b1});

    // Grant is held while any gesture is in progress or a scramble is running.
    assign w_freeze = (|bus.move_btn) | bus.rotate | w_busy;
    assign w_active = (|r_piece_sel) & ~w_busy;

    assign w_rise     = r_move & ~r_move_d;
    assign w_first    = w_rise & (~w_rise + 4'd1);
    assign w_scr_rise = r_scr & ~r_scr_d;
    assign w_cnt_done = (r_cnt == 8'(GAP - 1));
    assign w_last     = (r_idx == IDX_W'(N_PIECES - 1));

    // Input sampling plus one delayed copy for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_move   <= '0;
            r_move_d <= '0;
            r_rot    <= 1'b0;
            r_rot_d  <= 1'b0;
            r_scr    <= 1'b0;
            r_scr_d  <= 1'b0;
        end else begin
            r_move   <= bus.move_btn;
            r_move_d <= r_move;
            r_rot    <= bus.rotate;
            r_rot_d  <= r_rot;
            r_scr    <= bus.scramble_req;
            r_scr_d  <= r_scr;
        end
    end

    // Grant register: follows the candidate unless frozen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_piece_sel <= '0;
        end else if (!w_freeze) begin
            r_piece_sel <= w_cand;
        end
    end

`ifdef TANGRAM_AUTOREPEAT_EN
    logic [7:0] r_frm;
    logic       r_rep;
    logic [7:0] w_thr;
    logic       w_hold, w_fire;

    // Counting only while exactly one button has been steadily held since its first step.
    assign w_hold = (r_move != 4'd0) && ((r_move & (r_move - 4'd1)) == 4'd0)
                    && (r_move == r_move_d) && !w_busy;
    assign w_thr  = r_rep ? 8'(REPEAT_FRAMES) : 8'(FIRST_DELAY_FRAMES);
    assign w_fire = w_hold && bus.frame_tick && (({1'b0, r_frm} + 9'd1) >= {1'b0, w_thr});
    assign w_rep_step = w_fire ? r_move : 4'd0;

    // Saturating frame counter; restarts after each repeat step, clears when the hold breaks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frm <= 8'd0;
            r_rep <= 1'b0;
        end else if (!w_hold) begin
            r_frm <= 8'd0;
            r_rep <= 1'b0;
        end else if (bus.frame_tick) begin
            if (w_fire) begin
                r_frm <= 8'd0;
                r_rep <= 1'b1;
            end else if (r_frm != 8'hFF) begin
                r_frm <= r_frm + 8'd1;
            end
        end
    end
`else
    logic w_unused;

    assign w_rep_step = 4'd0;
    assign w_unused   = ^{bus.frame_tick, 8'(FIRST_DELAY_FRAMES), 8'(REPEAT_FRAMES)};
`endif

    // Press edges and repeat steps never coincide: a repeat needs an unchanged level.
    assign w_step = w_first | w_rep_step;

    // Registered step/rotate pulses, gated by a valid grant and no scramble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_move_step    <= 4'd0;
            r_rotate_pulse <= 1'b0;
        end else begin
            r_move_step    <= w_active ? w_step : 4'd0;
            r_rotate_pulse <= w_active & r_rot & ~r_rot_d;
        end
    end

    // Scramble FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Scramble spacing counter and piece index; IDLE preloads both to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= 8'd0;
            r_idx <= '0;
        end else if (r_state == S_RUN) begin
            if (w_cnt_done) begin
                r_cnt <= 8'd0;
                r_idx <= r_idx + IDX_W'(1);
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end else begin
            r_cnt <= 8'd0;
            r_idx <= '0;
        end
    end

    // Scramble FSM next state; HOLD waits for release so one press gives one sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_scr_rise) w_state_nxt = S_RUN;
            S_RUN:   if (w_cnt_done && w_last) w_state_nxt = S_HOLD;
            S_HOLD:  if (!r_scr) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Scramble FSM outputs: busy during RUN, one disturb pulse per elapsed gap.
    always_comb begin
        w_busy    = (r_state == S_RUN);
        w_disturb = '0;
        if ((r_state == S_RUN) && w_cnt_done) w_disturb[r_idx] = 1'b1;
    end

    assign bus.piece_sel    = r_piece_sel;
    assign bus.move_step    = r_move_step;
    assign bus.rotate_pulse = r_rotate_pulse;
    assign bus.disturb_flag = w_disturb;
    assign bus.busy         = w_busy;
endmodule

// File: tb/tb_tangram_piece_arbiter.sv
// Directed bench for tangram_piece_arbiter: vector table for grant/step behaviour,
// plus hand sequences for single step, scramble, reset mid-scramble and auto-repeat.
module tb_tangram_piece_arbiter;
    localparam int NP = 7;
    localparam int GP = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;

    tangram_piece_arbiter_if #(.N_PIECES(NP)) bus ();

    tangram_piece_arbiter #(
        .N_PIECES(NP), .GAP(GP), .FIRST_DELAY_FRAMES(20), .REPEAT_FRAMES(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] sel;
        logic [3:0] mv;
        logic       rot;
        logic [6:0] exp_sel;
        logic [3:0] exp_step;
        logic       exp_rot;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[17];
    int   n_chk = 0;
    int   n_pass = 0;

    int         npulse, nbusy, fbusy, nmv, nstep, pos, ticks;
    int         pc[7];
    logic [6:0] pb[7];
    int         st_t[8];
    logic       found;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // sel, move, rot | expected piece_sel, move_step, rotate_pulse, busy
        vecs[0]  = '{7'b0000000, 4'b0000, 1'b0, 7'b0000000, 4'b0000, 1'b0, 1'b0};
        vecs[1]  = '{7'b0010100, 4'b0000, 1'b0, 7'b0000100, 4'b0000, 1'b0, 1'b0};
        vecs[2]  = '{7'b0010100, 4'b0000, 1'b0, 7'b0000100, 4'b0000, 1'b0, 1'b0};
        vecs[3]  = '{7'b0010100, 4'b1000, 1'b0, 7'b0000100, 4'b0000, 1'b0, 1'b0};
        vecs[4]  = '{7'b0010100, 4'b1000, 1'b0, 7'b0000100, 4'b1000, 1'b0, 1'b0};
        vecs[5]  = '{7'b0010100, 4'b1000, 1'b0, 7'b0000100, 4'b0000, 1'b0, 1'b0};
        vecs[6]  = '{7'b0010100, 4'b0000, 1'b0, 7'b0000100, 4'b0000, 1'b0, 1'b0};
        vecs[7]  = '{7'b0010100, 4'b0110, 1'b1, 7'b0000100, 4'b0000, 1'b0, 1'b0};
        vecs[8]  = '{7'b0010100, 4'b0110, 1'b1, 7'b0000100, 4'b0010, 1'b1, 1'b0};
        vecs[9]  = '{7'b0010100, 4'b0000, 1'b0, 7'b0000100, 4'b0000, 1'b0, 1'b0};
        vecs[10] = '{7'b1000000, 4'b0100, 1'b0, 7'b0000100, 4'b0000, 1'b0, 1'b0};
        vecs[11] = '{7'b1000000, 4'b0100, 1'b0, 7'b0000100, 4'b0100, 1'b0, 1'b0};
        vecs[12] = '{7'b1000000, 4'b0000, 1'b0, 7'b1000000, 4'b0000, 1'b0, 1'b0};
        vecs[13] = '{7'b0000000, 4'b0000, 1'b0, 7'b0000000, 4'b0000, 1'b0, 1'b0};
        vecs[14] = '{7'b0000000, 4'b0001, 1'b0, 7'b0000000, 4'b0000, 1'b0, 1'b0};
        vecs[15] = '{7'b0000000, 4'b0001, 1'b0, 7'b0000000, 4'b0000, 1'b0, 1'b0};
        vecs[16] = '{7'b0000000, 4'b0000, 1'b0, 7'b0000000, 4'b0000, 1'b0, 1'b0};

        bus.select_sw = '0;
        bus.move_btn = '0;
        bus.rotate = 1'b0;
        bus.scramble_req = 1'b0;
        bus.frame_tick = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        check("reset_state", 32'({bus.piece_sel, bus.move_step, bus.rotate_pulse,
                                  bus.disturb_flag, bus.busy}), 32'd0);
        reset = 1'b0;

        // Grant priority/freeze, edge pulses, simultaneous press, no-grant suppression.
        for (int k = 0; k < 17; k++) begin
            bus.select_sw = vecs[k].sel;
            bus.move_btn  = vecs[k].mv;
            bus.rotate    = vecs[k].rot;
            tick();
            check($sformatf("vec%0d", k),
                  32'({bus.piece_sel, bus.move_step, bus.rotate_pulse, bus.busy}),
                  32'({vecs[k].exp_sel, vecs[k].exp_step, vecs[k].exp_rot, vecs[k].exp_busy}));
        end

        bus.select_sw = 7'b0000001;
        tick();

`ifndef TANGRAM_AUTOREPEAT_EN
        // One long press gives exactly one step, two edges after the press.
        nstep = 0;
        pos = -1;
        bus.move_btn = 4'b1000;
        for (int i = 1; i <= 1000; i++) begin
            bus.frame_tick = (i % 16 == 0);
            tick();
            if (bus.move_step != 4'd0) begin
                nstep++;
                if (pos < 0 && bus.move_step == 4'b1000) pos = i;
            end
        end
        check("single_step_count", 32'(nstep), 32'd1);
        check("single_step_latency", 32'(pos), 32'd2);
        bus.move_btn = 4'b0000;
        bus.frame_tick = 1'b0;
        tick();
        tick();
`endif

        // Scramble held high: one sequence, 10-cycle spacing, moves suppressed.
        npulse = 0;
        nbusy = 0;
        fbusy = -1;
        nmv = 0;
        bus.scramble_req = 1'b1;
        for (int i = 1; i <= 120; i++) begin
            bus.move_btn = (i >= 3 && i < 60 && (i % 6) < 3) ? 4'b0001 : 4'b0000;
            bus.rotate   = (i >= 4 && i < 60 && (i % 8) < 2);
            tick();
            if (bus.disturb_flag != '0) begin
                if (npulse < 7) begin
                    pc[npulse] = i;
                    pb[npulse] = bus.disturb_flag;
                end
                npulse++;
            end
            if (bus.busy) begin
                nbusy++;
                if (fbusy < 0) fbusy = i;
            end
            if (bus.move_step != 4'd0 || bus.rotate_pulse) nmv++;
        end
        check("scr_pulse_count", 32'(npulse), 32'd7);
        for (int k = 0; k < 7; k++) begin
            if (k < npulse) begin
                check($sformatf("scr_pulse%0d_cycle", k), 32'(pc[k]), 32'(11 + 10 * k));
                check($sformatf("scr_pulse%0d_bit", k), 32'(pb[k]), 32'(1 << k));
            end
        end
        check("scr_busy_len", 32'(nbusy), 32'd70);
        check("scr_busy_first", 32'(fbusy), 32'd2);
        check("scr_moves_suppressed", 32'(nmv), 32'd0);
        bus.scramble_req = 1'b0;
        tick();
        tick();
        tick();

        // Reset after the third pulse clears everything; the next request restarts at bit 0.
        npulse = 0;
        found = 1'b0;
        bus.scramble_req = 1'b1;
        for (int i = 1; i <= 100 && !found; i++) begin
            tick();
            if (bus.disturb_flag != '0) npulse++;
            if (npulse == 3) found = 1'b1;
        end
        check("rst_third_pulse_seen", 32'(found), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_mid_outputs", 32'({bus.piece_sel, bus.move_step, bus.rotate_pulse,
                                      bus.disturb_flag, bus.busy}), 32'd0);
        bus.scramble_req = 1'b0;
        #2;
        reset = 1'b0;
        tick();
        tick();
        pos = -1;
        pb[0] = '0;
        bus.scramble_req = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (pos < 0 && bus.disturb_flag != '0) begin
                pos = i;
                pb[0] = bus.disturb_flag;
            end
        end
        check("rst_restart_cycle", 32'(pos), 32'd11);
        check("rst_restart_bit", 32'(pb[0]), 32'd1);
        for (int i = 0; i < 60; i++) tick();
        bus.scramble_req = 1'b0;
        tick();
        tick();
        tick();

`ifdef TANGRAM_AUTOREPEAT_EN
        // Hold up for 44 frames: steps at press and after ticks 20, 28, 36, 44.
        nstep = 0;
        ticks = 0;
        bus.move_btn = 4'b0001;
        for (int i = 1; i <= 185; i++) begin
            bus.frame_tick = ((i % 4) == 3) && (ticks < 44);
            if (bus.frame_tick) ticks++;
            tick();
            if (bus.move_step != 4'd0) begin
                if (nstep < 8) st_t[nstep] = ticks;
                nstep++;
            end
        end
        bus.frame_tick = 1'b0;
        check("rep_step_count", 32'(nstep), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < nstep)
                check($sformatf("rep_step%0d_tick", k), 32'(st_t[k]),
                      32'((k == 0) ? 0 : 12 + 8 * k));
        end
        bus.move_btn = 4'b0000;
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/tangram_piece_arbiter.md
# tangram_piece_arbiter

Control block between the user inputs and the seven tangram shape controllers. It grants exactly one piece at a time from the select switches and turns debounced move/rotate buttons into single-cycle step pulses for the granted piece. It also sequences the scramble ("disturb") command as one pulse per piece, spaced in time. It replaces the ad-hoc select wiring and counter-based disturb decode in the VGA top level.

## Interface

**Parameters**
- `N_PIECES`, 7: number of shape controllers.
- `GAP`, 10: clock cycles between successive scramble pulses; legal range 2..255.
- `FIRST_DELAY_FRAMES`, 20: frames a move button is held before auto-repeat starts (macro-dependent).
- `REPEAT_FRAMES`, 8: frames between auto-repeat steps (macro-dependent).

**Ports**
- `clk` in 1: single clock, 40 MHz pixel clock.
- `reset` in 1: asynchronous, active-high; clears all state.
- `select_sw` in N_PIECES: raw switch levels; any number may be high.
- `move_btn` in 4: debounced move levels; [0]=up, [1]=down, [2]=left, [3]=right.
- `rotate` in 1: debounced rotate level.
- `scramble_req` in 1: debounced scramble level.
- `frame_tick` in 1: one-cycle pulse per frame.
- `piece_sel` out N_PIECES: one-hot grant, or all-zero.
- `move_step` out 4: at most one bit high, for one cycle.
- `rotate_pulse` out 1: one cycle per rotate press.
- `disturb_flag` out N_PIECES: one-hot scramble pulse, one cycle wide.
- `busy` out 1: high while a scramble is in progress.

## Operation

- **Reset values:** all outputs 0; FSM in IDLE; repeat counters 0.

**Grant**
- Candidate = lowest-index high bit of `select_sw`, or 0 if no bit is high.
- `piece_sel` loads the candidate only while all of `move_btn` and `rotate` are low and `busy`=0. Otherwise the grant is frozen, so the piece cannot change mid-gesture.

**Move and rotate**
- Each input is registered, and its rising edge is detected.
- A `move_btn` edge produces a `move_step` pulse for that direction.
- If several edges occur in the same cycle, the lowest index wins. The others are dropped, not queued.
- A `rotate` edge produces `rotate_pulse`. It is independent of `move_step`; both may be high in the same cycle.
- All step and rotate pulses are suppressed when `piece_sel`=0 or `busy`=1.

**Scramble FSM**
- IDLE: on a rising edge of `scramble_req` → RUN, with idx=0 and cnt=0.
- RUN: `busy`=1. When cnt=GAP-1, pulse `disturb_flag[idx]` for one cycle, clear cnt and increment idx. After the pulse with idx=N_PIECES-1 → HOLD.
- HOLD: `busy`=0. Stay until `scramble_req` is low → IDLE. This guarantees one scramble per press.
- A new `scramble_req` edge during RUN is ignored.
- Asserting `reset` in any state → IDLE immediately, with `disturb_flag` cleared.

## Timing

- Latency is 2 cycles from an input level change at clock edge t (sampled by the input register) to the output pulse in the cycle after edge t+1.
- `piece_sel` updates 1 cycle after `select_sw` changes, provided it is not frozen.
- Scramble pulses:
  - The first pulse occurs GAP cycles after the edge-detect cycle.
  - Consecutive pulses are exactly GAP cycles apart.
  - A full sequence lasts N_PIECES×GAP cycles.
- `busy` rises in the cycle after the edge is detected. It falls in the cycle after the last pulse.
- Counter widths: cnt is 8 bits; idx is ceil(log2 N_PIECES) bits; frame counters are 8 bits, and they saturate rather than wrap.

## Configuration

- **`TANGRAM_AUTOREPEAT_EN` defined:**
  - While a single move button stays high after its initial step, count `frame_tick`.
  - After FIRST_DELAY_FRAMES ticks, issue one step. After that, issue one step every REPEAT_FRAMES ticks.
  - Each step is issued in the cycle after the qualifying tick.
  - Releasing the button, pressing a second button, or asserting `busy` clears the counter.
- **Undefined:** exactly one step per press. Frame counters are absent, and `frame_tick` is unused.

## Test plan

- **Grant priority and freeze:**
  - `select_sw`=7'b0010100 → `piece_sel`=7'b0000100.
  - Hold `move_btn[2]`, then change `select_sw` to 7'b1000000 → `piece_sel` is unchanged until release, then becomes 7'b1000000 one cycle later.
- **Single step:** press `move_btn[3]` for 1000 cycles with macro off → exactly one `move_step`=4'b1000 pulse, 2 cycles after the press.
- **Simultaneous press:** `move_btn` goes 0→4'b0110 in one cycle → one pulse with `move_step`=4'b0010 only; `rotate` pressed in the same cycle also yields `rotate_pulse`.
- **Scramble:** with GAP=10, pulse `scramble_req` high → `disturb_flag` bits 0..6 fire at 10-cycle spacing, `busy` is high for 70 cycles, and moves are suppressed throughout. Holding `scramble_req` high afterwards → no second sequence.
- **Reset mid-scramble:** assert `reset` after the third pulse → all outputs 0 immediately. A new request then restarts the sequence at bit 0.
- **Auto-repeat (macro on, FIRST_DELAY_FRAMES=20, REPEAT_FRAMES=8):** hold `move_btn[0]` for 44 frames → steps at press, after tick 20, after tick 28, after tick 36 and after tick 44, for 5 steps total.
